chest_equalizer: RTL and testbench
==================================

Name: chest_equalizer

Overview:
- Downstream consumer of the channel-estimation interpolation stage.
- Takes the two interpolated channel coefficients it emits per cycle (real/imag, one per subcarrier), plus the matching two received data samples.
- Computes the zero-forcing numerator z = conj(h)·y for both subcarriers in a 2-stage pipeline with valid/ready flow control.
- Tags the last subcarrier pair of each resource block for the downstream demapper.

Parameters:
- H_WIDTH, 17, signed width of each channel coefficient component (matches interpolation OUT_WIDTH).
- Y_WIDTH, 16, signed width of each received-sample component.
- OUT_WIDTH, 16, signed width of each equalized output component.
- SHIFT, 15, arithmetic right-shift applied to the product sums before saturation (must be ≥1).
- PAIRS, 6, subcarrier pairs per resource block (12 subcarriers / 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  h/y inputs valid this cycle.
- in_ready  out  1  block accepts inputs this cycle.
- h1_r, h1_i, h2_r, h2_i  in  H_WIDTH each  channel coefficients for subcarriers 2k and 2k+1.
- y1_r, y1_i, y2_r, y2_i  in  Y_WIDTH each  received samples for the same subcarriers.
- flush  in  1  synchronous clear of pipeline valids and the pair counter.
- out_valid  out  1  outputs valid.
- out_ready  in  1  downstream accepts outputs.
- z1_r, z1_i, z2_r, z2_i  out  OUT_WIDTH each  equalized samples.
- out_last  out  1  high with the PAIRS-th output pair of a resource block.

Behaviour:
- Reset (async, rst=1): pipeline valid bits v1, v2 = 0, pair counter = 0.
  - Outputs: out_valid = 0, out_last = 0, all z* = 0.
  - in_ready = 1 combinationally once rst is deasserted.
- Global advance: adv = !out_valid || out_ready; in_ready = adv.
  - Input handshake is in_valid && in_ready.
  - Output handshake is out_valid && out_ready.
- Stage 1 (on adv): register the 4 signed products per subcarrier: hr·yr, hi·yi, hr·yi, hi·yr (H_WIDTH+Y_WIDTH bits each). v1 <= in_valid.
- Stage 2 (on adv), per subcarrier:
  - re = hr·yr + hi·yi; im = hr·yi − hi·yr, both H_WIDTH+Y_WIDTH+1 bits sign-extended.
  - Add 2^(SHIFT−1), then arithmetic shift right by SHIFT.
  - Saturate to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
  - Register into z*. v2 <= v1. out_valid = v2.
- Latency: exactly 2 cycles from input handshake to out_valid when out_ready stays high. Throughput is one pair per cycle.
- Stall: when out_valid=1 and out_ready=0, every register holds (z*, products, v1, v2, counter) and in_ready=0. Inputs must be held by the upstream stage.
- Bubbles: a cycle with in_valid=0 during adv propagates a 0 valid. Bubbles are not squeezed out.
- Pair counter: increments on each output handshake and wraps PAIRS−1 → 0. out_last = out_valid && (counter == PAIRS−1).
- flush:
  - Clears v1, v2 and the counter on the next edge and has priority over adv.
  - Data registers are don't-care after flush.
  - in_ready stays driven by adv, but any input accepted in the flush cycle is discarded.
- Simultaneous output handshake and flush: flush wins; counter = 0; the handshaked output counts as consumed.
- Reset mid-transfer: in-flight pairs are dropped without further output.

Test Plan:
- Basic product: h1=(16384,0), y1=(1000,−2000), out_ready=1 → 2 cycles later out_valid=1, z1=(500,−1000); h2=y2=0 → z2=(0,0).
- Conjugate check: h1=(0,16384), y1=(2000,0) → z1=(0,−1000); h1=(16384,16384), y1=(2000,2000) → z1=(2000,0).
- Saturation: h1=(65535,65535), y1=(32767,32767) → z1=(32767,0). Same h with y1=(−32768,−32768) → z1=(−32768,0).
- Back-pressure: stream 6 pairs, drop out_ready for 3 cycles after the 2nd output.
  - in_ready=0 and z* held stable during the stall.
  - All 6 pairs are delivered in order with no loss or duplication.
  - out_last only on the 6th pair.
- Counter wrap/last: 13 back-to-back pairs → out_last on outputs 6 and 12 only; the 13th output has counter=0.
- flush/reset: assert flush with 2 pairs in flight → out_valid stays 0 after the flush and the next pair restarts counting at 0. Assert rst asynchronously mid-stream → out_valid and out_last drop without a clock edge.

Source files
------------

// File: rtl/chest_equalizer_if.sv
// Handshake and data bundle between the channel interpolator, the equalizer
// and the demapper: h/y pairs in, conj(h)*y pairs out.
interface chest_equalizer_if #(
  parameter int H_WIDTH   = 17,
  parameter int Y_WIDTH   = 16,
  parameter int OUT_WIDTH = 16
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        flush;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;
  logic signed [H_WIDTH-1:0]   h1_r, h1_i, h2_r, h2_i;
  logic signed [Y_WIDTH-1:0]   y1_r, y1_i, y2_r, y2_i;
  logic signed [OUT_WIDTH-1:0] z1_r, z1_i, z2_r, z2_i;

  modport master (
    output in_valid, flush, out_ready,
    output h1_r, h1_i, h2_r, h2_i, y1_r, y1_i, y2_r, y2_i,
    input  in_ready, out_valid, out_last,
    input  z1_r, z1_i, z2_r, z2_i
  );

  modport slave (
    input  in_valid, flush, out_ready,
    input  h1_r, h1_i, h2_r, h2_i, y1_r, y1_i, y2_r, y2_i,
    output in_ready, out_valid, out_last,
    output z1_r, z1_i, z2_r, z2_i
  );
endinterface

// File: rtl/chest_equalizer.sv
// Zero-forcing numerator z = conj(h)*y for two subcarriers per cycle,
// two-stage pipeline with a global stall and resource-block last tagging.
module chest_equalizer #(
  parameter int H_WIDTH   = 17,
  parameter int Y_WIDTH   = 16,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15,
  parameter int PAIRS     = 6
) (
  input logic             clk,
  input logic             rst,
  chest_equalizer_if.slave bus
);
  localparam int PW = H_WIDTH + Y_WIDTH;
  localparam int SW = PW + 1;
  localparam int CW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);
  localparam logic signed [SW-1:0] RND  = {{(SW-1){1'b0}}, 1'b1} <<< (SHIFT - 1);
  localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [H_WIDTH-1:0]   h_r [2];
  logic signed [H_WIDTH-1:0]   h_i [2];
  logic signed [Y_WIDTH-1:0]   y_r [2];
  logic signed [Y_WIDTH-1:0]   y_i [2];
  logic signed [PW-1:0]        p_rr [2];
  logic signed [PW-1:0]        p_ii [2];
  logic signed [PW-1:0]        p_ri [2];
  logic signed [PW-1:0]        p_ir [2];
  logic signed [OUT_WIDTH-1:0] z_r [2];
  logic signed [OUT_WIDTH-1:0] z_i [2];
  logic                        v1, v2;
  logic [CW-1:0]               cnt;
  logic                        adv;
  logic                        out_hs;

  // Round half up, scale down, then clamp to the output range.
  function automatic logic signed [OUT_WIDTH-1:0] scale(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] r;
    r = (s + RND) >>> SHIFT;
    if (r > MAXV)      return MAXV[OUT_WIDTH-1:0];
    else if (r < MINV) return MINV[OUT_WIDTH-1:0];
    else               return r[OUT_WIDTH-1:0];
  endfunction

  assign h_r[0] = bus.h1_r;
  assign h_i[0] = bus.h1_i;
  assign h_r[1] = bus.h2_r;
  assign h_i[1] = bus.h2_i;
  assign y_r[0] = bus.y1_r;
  assign y_i[0] = bus.y1_i;
  assign y_r[1] = bus.y2_r;
  assign y_i[1] = bus.y2_i;

  assign adv    = !v2 || bus.out_ready;
  assign out_hs = v2 && bus.out_ready;

  assign bus.in_ready  = adv;
  assign bus.out_valid = v2;
  assign bus.out_last  = v2 && (cnt == LAST);
  assign bus.z1_r      = z_r[0];
  assign bus.z1_i      = z_i[0];
  assign bus.z2_r      = z_r[1];
  assign bus.z2_i      = z_i[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        p_rr[k] <= '0;
        p_ii[k] <= '0;
        p_ri[k] <= '0;
        p_ir[k] <= '0;
        z_r[k]  <= '0;
        z_i[k]  <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < 2; k++) begin
        p_rr[k] <= PW'(h_r[k]) * PW'(y_r[k]);
        p_ii[k] <= PW'(h_i[k]) * PW'(y_i[k]);
        p_ri[k] <= PW'(h_r[k]) * PW'(y_i[k]);
        p_ir[k] <= PW'(h_i[k]) * PW'(y_r[k]);
        z_r[k]  <= scale(SW'(p_rr[k]) + SW'(p_ii[k]));
        z_i[k]  <= scale(SW'(p_ri[k]) - SW'(p_ir[k]));
      end
    end
  end

  // Flush beats the advance, so a pair handshaked in the flush cycle is simply gone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      cnt <= '0;
    end else if (bus.flush) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      cnt <= '0;
    end else begin
      if (adv) begin
        v1 <= bus.in_valid;
        v2 <= v1;
      end
      if (out_hs) begin
        if (cnt == LAST) cnt <= '0;
        else             cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_chest_equalizer.sv
// Directed bench for chest_equalizer: products, conjugation, saturation,
// back-pressure, last tagging, flush and asynchronous reset.
module tb_chest_equalizer;
  localparam int HW = 17;
  localparam int YW = 16;
  localparam int OW = 16;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  chest_equalizer_if #(.H_WIDTH(HW), .Y_WIDTH(YW), .OUT_WIDTH(OW)) bus ();

  chest_equalizer #(
    .H_WIDTH(HW), .Y_WIDTH(YW), .OUT_WIDTH(OW), .SHIFT(15), .PAIRS(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.h1_r = '0; bus.h1_i = '0; bus.h2_r = '0; bus.h2_i = '0;
    bus.y1_r = '0; bus.y1_i = '0; bus.y2_r = '0; bus.y2_i = '0;
  endtask

  task automatic drive(input int h1r, h1i, h2r, h2i, y1r, y1i, y2r, y2i);
    bus.in_valid = 1'b1;
    bus.h1_r = HW'(h1r); bus.h1_i = HW'(h1i); bus.h2_r = HW'(h2r); bus.h2_i = HW'(h2i);
    bus.y1_r = YW'(y1r); bus.y1_i = YW'(y1i); bus.y2_r = YW'(y2r); bus.y2_i = YW'(y2i);
  endtask

  // Pair k gives z1 = (50k, -50k) and z2 = (0, -100k).
  task automatic drive_k(input int k);
    drive(16384, 0, 0, 16384, 100*k, -100*k, 200*k, 0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if ({bus.out_valid, bus.out_last} !== 2'b00)
      $display("[TB] FAIL reset_flags: got valid/last=%b%b expected 00", bus.out_valid, bus.out_last);
    else passes++;
    checks++;
    if ({bus.z1_r, bus.z1_i, bus.z2_r, bus.z2_i} !== {4{OW'(0)}})
      $display("[TB] FAIL reset_z: got %h %h %h %h expected all 0", bus.z1_r, bus.z1_i, bus.z2_r, bus.z2_i);
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1)
      $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    else passes++;
  endtask

  task automatic test_basic;
    do_reset();
    drive(16384, 0, 0, 0, 1000, -2000, 0, 0);
    tick();
    idle_inputs();
    checks++;
    if (bus.out_valid !== 1'b0)
      $display("[TB] FAIL basic_latency1: got out_valid=%b expected 0", bus.out_valid);
    else passes++;
    tick();
    checks++;
    if ({bus.out_valid, bus.z1_r, bus.z1_i, bus.z2_r, bus.z2_i} !== {1'b1, OW'(500), OW'(-1000), OW'(0), OW'(0)})
      $display("[TB] FAIL basic_product: got v=%b z=%0d,%0d,%0d,%0d expected v=1 z=500,-1000,0,0",
               bus.out_valid, bus.z1_r, bus.z1_i, bus.z2_r, bus.z2_i);
    else passes++;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0)
      $display("[TB] FAIL basic_single: got out_valid=%b expected 0", bus.out_valid);
    else passes++;
  endtask

  task automatic test_conjugate;
    do_reset();
    drive(0, 16384, 0, 0, 2000, 0, 0, 0);
    tick();
    drive(16384, 16384, 0, 0, 2000, 2000, 0, 0);
    tick();
    idle_inputs();
    checks++;
    if ({bus.out_valid, bus.z1_r, bus.z1_i} !== {1'b1, OW'(0), OW'(-1000)})
      $display("[TB] FAIL conj_imag_h: got v=%b z1=%0d,%0d expected v=1 z1=0,-1000", bus.out_valid, bus.z1_r, bus.z1_i);
    else passes++;
    tick();
    checks++;
    if ({bus.out_valid, bus.z1_r, bus.z1_i} !== {1'b1, OW'(2000), OW'(0)})
      $display("[TB] FAIL conj_diag_h: got v=%b z1=%0d,%0d expected v=1 z1=2000,0", bus.out_valid, bus.z1_r, bus.z1_i);
    else passes++;
  endtask

  task automatic test_saturation;
    do_reset();
    drive(65535, 65535, 0, 0, 32767, 32767, 0, 0);
    tick();
    drive(65535, 65535, 0, 0, -32768, -32768, 0, 0);
    tick();
    idle_inputs();
    checks++;
    if ({bus.out_valid, bus.z1_r, bus.z1_i} !== {1'b1, OW'(32767), OW'(0)})
      $display("[TB] FAIL sat_pos: got v=%b z1=%0d,%0d expected v=1 z1=32767,0", bus.out_valid, bus.z1_r, bus.z1_i);
    else passes++;
    tick();
    checks++;
    if ({bus.out_valid, bus.z1_r, bus.z1_i} !== {1'b1, OW'(-32768), OW'(0)})
      $display("[TB] FAIL sat_neg: got v=%b z1=%0d,%0d expected v=1 z1=-32768,0", bus.out_valid, bus.z1_r, bus.z1_i);
    else passes++;
  endtask

  task automatic test_back_pressure;
    int idx, n_out, stall_left;
    bit in_hs;
    do_reset();
    idx = 0; n_out = 0; stall_left = 0;
    for (int cyc = 0; cyc < 40 && n_out < 6; cyc++) begin
      bus.out_ready = (stall_left == 0);
      if (idx < 6) drive_k(idx + 1);
      else         idle_inputs();
      #1;
      in_hs = bus.in_valid && bus.in_ready;
      if (bus.out_valid && !bus.out_ready) begin
        checks++;
        if ({bus.in_ready, bus.z1_r, bus.z2_i} !== {1'b0, OW'(50*(n_out+1)), OW'(-100*(n_out+1))})
          $display("[TB] FAIL bp_stall: got in_ready=%b z1_r=%0d z2_i=%0d expected 0,%0d,%0d",
                   bus.in_ready, bus.z1_r, bus.z2_i, 50*(n_out+1), -100*(n_out+1));
        else passes++;
      end else if (bus.out_valid) begin
        checks++;
        if ({bus.out_last, bus.z1_r, bus.z1_i, bus.z2_r, bus.z2_i} !==
            {(n_out == 5), OW'(50*(n_out+1)), OW'(-50*(n_out+1)), OW'(0), OW'(-100*(n_out+1))})
          $display("[TB] FAIL bp_output%0d: got last=%b z=%0d,%0d,%0d,%0d expected last=%b z=%0d,%0d,0,%0d",
                   n_out, bus.out_last, bus.z1_r, bus.z1_i, bus.z2_r, bus.z2_i,
                   (n_out == 5), 50*(n_out+1), -50*(n_out+1), -100*(n_out+1));
        else passes++;
        n_out++;
        if (n_out == 2) stall_left = 3;
      end
      if (!bus.out_ready) stall_left--;
      tick();
      if (in_hs) idx++;
    end
    checks++;
    if (n_out != 6)
      $display("[TB] FAIL bp_count: got %0d outputs expected 6", n_out);
    else passes++;
    idle_inputs();
    checks++;
    if (bus.out_valid !== 1'b0)
      $display("[TB] FAIL bp_no_dup: got out_valid=%b expected 0", bus.out_valid);
    else passes++;
  endtask

  task automatic test_counter_wrap;
    int n;
    do_reset();
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (cyc < 13) drive_k(cyc + 1);
      else          idle_inputs();
      #1;
      if (cyc >= 2) begin
        n = cyc - 2;
        checks++;
        if ({bus.out_valid, bus.out_last, bus.z1_r} !== {1'b1, (n % 6 == 5), OW'(50*(n+1))})
          $display("[TB] FAIL wrap_output%0d: got v=%b last=%b z1_r=%0d expected v=1 last=%b z1_r=%0d",
                   n, bus.out_valid, bus.out_last, bus.z1_r, (n % 6 == 5), 50*(n+1));
        else passes++;
      end
      tick();
    end
  endtask

  task automatic test_flush;
    int n;
    do_reset();
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc < 3) drive_k(cyc + 1);
      else         idle_inputs();
      tick();
    end
    drive_k(4);
    tick();
    drive_k(5);
    tick();
    idle_inputs();
    checks++;
    if ({bus.out_valid, bus.z1_r} !== {1'b1, OW'(200)})
      $display("[TB] FAIL flush_inflight: got v=%b z1_r=%0d expected v=1 z1_r=200", bus.out_valid, bus.z1_r);
    else passes++;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0)
      $display("[TB] FAIL flush_clear: got out_valid=%b expected 0", bus.out_valid);
    else passes++;
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0)
      $display("[TB] FAIL flush_drain: got out_valid=%b expected 0", bus.out_valid);
    else passes++;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc < 6) drive_k(cyc + 1);
      else         idle_inputs();
      #1;
      if (cyc >= 2) begin
        n = cyc - 2;
        checks++;
        if ({bus.out_valid, bus.out_last, bus.z1_r} !== {1'b1, (n == 5), OW'(50*(n+1))})
          $display("[TB] FAIL flush_restart%0d: got v=%b last=%b z1_r=%0d expected v=1 last=%b z1_r=%0d",
                   n, bus.out_valid, bus.out_last, bus.z1_r, (n == 5), 50*(n+1));
        else passes++;
      end
      tick();
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    for (int cyc = 0; cyc < 7; cyc++) begin
      drive_k(cyc + 1);
      tick();
    end
    drive_k(8);
    #1;
    checks++;
    if ({bus.out_valid, bus.out_last, bus.z1_r} !== {1'b1, 1'b1, OW'(300)})
      $display("[TB] FAIL arst_before: got v=%b last=%b z1_r=%0d expected 1,1,300", bus.out_valid, bus.out_last, bus.z1_r);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_last, bus.z1_r} !== {1'b0, 1'b0, OW'(0)})
      $display("[TB] FAIL arst_drop: got v=%b last=%b z1_r=%0d expected 0,0,0", bus.out_valid, bus.out_last, bus.z1_r);
    else passes++;
    tick();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0)
      $display("[TB] FAIL arst_no_resume: got out_valid=%b expected 0", bus.out_valid);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst    = 1'b1;
    idle_inputs();
    bus.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_conjugate();
    test_saturation();
    test_back_pressure();
    test_counter_wrap();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
